uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 The block SHALL have parameter PARITY_MODE, default 2'b00, meaning 00 none, 01 even, 10 odd, 11 none.
REQ-003 The block SHALL have parameter NB_STOP, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-004 The block SHALL have parameter CLK_FREQ, default 100000000, meaning system clock in Hz.
REQ-005 The block SHALL have parameter BAUD_RATE, default 115200, meaning line rate in bit/s.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 i_rst  input  1  reset, asynchronous, active-high.
REQ-008 i_data  input  NB_DATA  payload, sampled only at handshake.
REQ-009 i_valid  input  1  producer has a payload.
REQ-010 o_ready  output  1  block can accept a payload this cycle.
REQ-011 o_tx  output  1  serial line, idle high.
REQ-012 o_busy  output  1  frame in progress.
REQ-013 o_done  output  1  one-cycle pulse at frame end.

Function
REQ-014 The block SHALL derive DIVISOR = CLK_FREQ/BAUD_RATE (integer truncation); every line bit SHALL last exactly DIVISOR clk cycles.
REQ-015 Handshake: a payload SHALL be accepted on the rising edge where i_valid=1 and o_ready=1; i_data is captured there and later changes are ignored.
REQ-016 o_ready SHALL be 1 only in IDLE; i_valid while busy is ignored, with no queuing.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; transitions: IDLE->START on accept, START->DATA, DATA->PARITY or STOP after NB_DATA bits, PARITY->STOP, STOP->IDLE after NB_STOP bits; all but IDLE->START occur at a bit-period boundary.
REQ-018 The baud counter SHALL restart at accept so the start bit is full length; the cycle after accept, o_tx=0.
REQ-019 Data bits SHALL be sent LSB first; the PARITY state is skipped when PARITY_MODE is 00 or 11.
REQ-020 Even parity bit = XOR of the NB_DATA bits; odd parity bit = its inverse.
REQ-021 Stop bits SHALL be 1.
REQ-022 Frame length SHALL be (1+NB_DATA+P+NB_STOP)*DIVISOR cycles, where P=1 with parity and P=0 without.
REQ-023 o_done SHALL pulse for one cycle on the cycle the FSM re-enters IDLE; o_ready rises in that same cycle.
REQ-024 Back-to-back: if i_valid=1 in the o_done cycle, the next start bit SHALL begin on the following cycle, with no extra idle bit.
REQ-025 o_busy SHALL equal NOT o_ready.
REQ-026 In IDLE, o_tx SHALL be 1.

Reset
REQ-027 While i_rst=1, the block SHALL hold state IDLE, o_tx=1, o_ready=1, o_busy=0, o_done=0, baud and bit counters 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (o_tx=1 asynchronously) with no o_done; the first accept after release starts a fresh frame.

Structure
REQ-029 A shared package uart_pkg SHALL hold the parity-mode encodings and the FSM state encoding.
REQ-030 The block SHALL instantiate one sub-module, uart_baud_tick: a counter 0..DIVISOR-1 with synchronous restart input and one-cycle tick output, also reset by i_rst.
REQ-031 The bit counter width SHALL be sized to hold NB_DATA; the baud counter width SHALL be sized to hold DIVISOR-1.

Verification (CLK_FREQ=16, BAUD_RATE=1, DIVISOR=16)
REQ-032 8N1: send 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; o_done 160 cycles after the accept+1 cycle.
REQ-033 8E1 and 8O1: send 0x07 -> parity bit is 1 (even) and 0 (odd); frame length 176 cycles.
REQ-034 7N2: send 0x7F -> start bit, seven 1s, two stop bits; 160 cycles total; o_ready low throughout.
REQ-035 Back-to-back: hold i_valid=1 with 0x55 then 0xAA -> the second start bit immediately follows the first stop bit; exactly two o_done pulses.
REQ-036 Reset at cycle 40 of a frame -> o_tx=1 at once, no o_done; a new 0x3C after release is sent correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings and the transmit FSM state encoding.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE     = 2'b00;
    localparam logic [1:0] PARITY_EVEN     = 2'b01;
    localparam logic [1:0] PARITY_ODD      = 2'b10;
    localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic has_parity(input logic [1:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..DIVISOR-1 and flags the last cycle of each bit period.
module uart_baud_tick #(
    parameter int DIVISOR = 16
) (
    input  logic clk,
    input  logic i_rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: accepts one payload per frame over a valid/ready handshake and
// serialises start, LSB-first data, optional parity and stop bits onto o_tx.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int         NB_DATA     = 8,
    parameter logic [1:0] PARITY_MODE = 2'b00,
    parameter int         NB_STOP     = 1,
    parameter int         CLK_FREQ    = 100000000,
    parameter int         BAUD_RATE   = 115200
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done
);

    localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
    localparam int BIT_W = $clog2(NB_DATA + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(NB_DATA - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(NB_STOP - 1);
    localparam logic WITH_PARITY = has_parity(PARITY_MODE);
    localparam logic ODD_PARITY = (PARITY_MODE == PARITY_ODD);

    tx_state_e          state_q;
    logic               tx_q;
    logic               ready_q;
    logic               done_q;
    logic [NB_DATA-1:0] shift_q;
    logic               parity_q;
    logic [BIT_W-1:0]   bit_q;

    logic accept;
    logic baudTick;

    assign accept = i_valid && ready_q;

    // Restarting the timer at accept makes the start bit a full period long.
    uart_baud_tick #(
        .DIVISOR(DIVISOR)
    ) u_baud (
        .clk      (clk),
        .i_rst    (i_rst),
        .restart_i(accept),
        .tick_o   (baudTick)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            bit_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (accept) begin
                        state_q  <= ST_START;
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        shift_q  <= i_data;
                        parity_q <= (^i_data) ^ ODD_PARITY;
                        bit_q    <= '0;
                    end
                end
                ST_START: begin
                    if (baudTick) begin
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                ST_DATA: begin
                    if (baudTick) begin
                        if (bit_q == LAST_DATA) begin
                            bit_q <= '0;
                            if (WITH_PARITY) begin
                                state_q <= ST_PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (baudTick) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                // The stop phase reuses the bit counter to count stop bits.
                ST_STOP: begin
                    if (baudTick) begin
                        if (bit_q == LAST_STOP) begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            bit_q   <= '0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    bit_q   <= '0;
                end
            endcase
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = ~ready_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench: four framer configurations (8N1, 8E1, 8O1, 7N2) at DIVISOR=16,
// checked cycle by cycle against a bit-list model of each frame.
module tb_uart_tx_framer;

    localparam int DIV = 16;
    localparam int NDUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       validIn  [NDUT];
    logic [8:0] dataIn   [NDUT];
    logic       txOut    [NDUT];
    logic       readyOut [NDUT];
    logic       busyOut  [NDUT];
    logic       doneOut  [NDUT];

    int nbDataCfg [NDUT] = '{8, 8, 8, 7};
    int parityCfg [NDUT] = '{0, 1, 2, 0};
    int nbStopCfg [NDUT] = '{1, 1, 1, 2};

    int total = 0;
    int bad = 0;
    int expBits [$];
    logic [8:0] burst [$];

    always #5 clk = ~clk;

    uart_tx_framer #(.NB_DATA(8), .PARITY_MODE(2'b00), .NB_STOP(1), .CLK_FREQ(16), .BAUD_RATE(1)) dut8n1 (
        .clk(clk), .i_rst(reset), .i_data(dataIn[0][7:0]), .i_valid(validIn[0]),
        .o_ready(readyOut[0]), .o_tx(txOut[0]), .o_busy(busyOut[0]), .o_done(doneOut[0]));

    uart_tx_framer #(.NB_DATA(8), .PARITY_MODE(2'b01), .NB_STOP(1), .CLK_FREQ(16), .BAUD_RATE(1)) dut8e1 (
        .clk(clk), .i_rst(reset), .i_data(dataIn[1][7:0]), .i_valid(validIn[1]),
        .o_ready(readyOut[1]), .o_tx(txOut[1]), .o_busy(busyOut[1]), .o_done(doneOut[1]));

    uart_tx_framer #(.NB_DATA(8), .PARITY_MODE(2'b10), .NB_STOP(1), .CLK_FREQ(16), .BAUD_RATE(1)) dut8o1 (
        .clk(clk), .i_rst(reset), .i_data(dataIn[2][7:0]), .i_valid(validIn[2]),
        .o_ready(readyOut[2]), .o_tx(txOut[2]), .o_busy(busyOut[2]), .o_done(doneOut[2]));

    uart_tx_framer #(.NB_DATA(7), .PARITY_MODE(2'b00), .NB_STOP(2), .CLK_FREQ(16), .BAUD_RATE(1)) dut7n2 (
        .clk(clk), .i_rst(reset), .i_data(dataIn[3][6:0]), .i_valid(validIn[3]),
        .o_ready(readyOut[3]), .o_tx(txOut[3]), .o_busy(busyOut[3]), .o_done(doneOut[3]));

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d, want %0d", tag, $time, observed, expected);
        end
    endtask

    // Expected line levels for one frame, one entry per bit period.
    task automatic buildFrame(input int idx, input logic [8:0] d);
        int ones;
        ones = 0;
        expBits.delete();
        expBits.push_back(0);
        for (int i = 0; i < nbDataCfg[idx]; i++) begin
            expBits.push_back(int'(d[i]));
            ones += int'(d[i]);
        end
        if (parityCfg[idx] == 1) expBits.push_back(ones % 2);
        else if (parityCfg[idx] == 2) expBits.push_back(1 - (ones % 2));
        for (int i = 0; i < nbStopCfg[idx]; i++) expBits.push_back(1);
    endtask

    // Sends every payload in burst back-to-back, holding valid high between frames.
    task automatic applyStimulus(input int idx);
        int count;
        int earlyDone;
        count = burst.size();
        @(negedge clk);
        validIn[idx] = 1'b1;
        dataIn[idx] = burst[0];
        checkOutput("readyIdle", int'(readyOut[idx]), 1);
        for (int f = 0; f < count; f++) begin
            buildFrame(idx, burst[f]);
            @(posedge clk);
            @(negedge clk);
            if (f + 1 < count) begin
                dataIn[idx] = burst[f + 1];
            end else begin
                validIn[idx] = 1'b0;
                dataIn[idx] = 9'($urandom);
            end
            earlyDone = 0;
            for (int k = 0; k < expBits.size() * DIV; k++) begin
                checkOutput("txBit", int'(txOut[idx]), expBits[k / DIV]);
                checkOutput("readyBusy", int'(readyOut[idx]), 0);
                if (k % DIV == 0) checkOutput("busyHigh", int'(busyOut[idx]), 1);
                earlyDone += int'(doneOut[idx]);
                @(negedge clk);
            end
            checkOutput("noEarlyDone", earlyDone, 0);
            checkOutput("donePulse", int'(doneOut[idx]), 1);
            checkOutput("readyAtDone", int'(readyOut[idx]), 1);
            checkOutput("busyAtDone", int'(busyOut[idx]), 0);
            checkOutput("txIdleAtDone", int'(txOut[idx]), 1);
        end
        @(negedge clk);
        checkOutput("doneOneCycle", int'(doneOut[idx]), 0);
        checkOutput("txIdleAfter", int'(txOut[idx]), 1);
        checkOutput("readyAfter", int'(readyOut[idx]), 1);
    endtask

    task automatic checkResetState(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            checkOutput({tag, "Tx"}, int'(txOut[i]), 1);
            checkOutput({tag, "Ready"}, int'(readyOut[i]), 1);
            checkOutput({tag, "Busy"}, int'(busyOut[i]), 0);
            checkOutput({tag, "Done"}, int'(doneOut[i]), 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            validIn[i] = 1'b0;
            dataIn[i] = '0;
        end
        repeat (3) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        burst = '{9'h0A5};
        applyStimulus(0);
        burst = '{9'h007};
        applyStimulus(1);
        burst = '{9'h007};
        applyStimulus(2);
        burst = '{9'h07F};
        applyStimulus(3);
        burst = '{9'h055, 9'h0AA};
        applyStimulus(0);

        for (int i = 0; i < NDUT; i++) begin
            burst = '{9'($urandom), 9'($urandom), 9'($urandom)};
            applyStimulus(i);
            burst = '{9'($urandom)};
            applyStimulus(i);
        end

        // Abort a frame mid-data with an all-zero payload so the line is low when reset hits.
        @(negedge clk);
        validIn[0] = 1'b1;
        dataIn[0] = 9'h000;
        @(posedge clk);
        @(negedge clk);
        validIn[0] = 1'b0;
        repeat (39) @(negedge clk);
        checkOutput("midFrameLow", int'(txOut[0]), 0);
        reset = 1'b1;
        #1;
        checkResetState("abort");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("abortNoDone", int'(doneOut[0]), 0);
        end
        reset = 1'b0;
        for (int c = 0; c < 2 * DIV; c++) begin
            @(negedge clk);
            checkOutput("postResetIdleTx", int'(txOut[0]), 1);
            checkOutput("postResetNoDone", int'(doneOut[0]), 0);
        end
        burst = '{9'h03C};
        applyStimulus(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
